// File: rtl/mem_stage_if.sv
// Data-bus handshake between the memory stage and the data memory:
// req/gnt request phase followed by an rvalid response phase.
interface mem_stage_if #(
  parameter int ADDR_W = 32
) ();
  logic              data_req_out;
  logic [ADDR_W-1:0] data_addr_out;
  logic              data_we_out;
  logic [3:0]        data_be_out;
  logic [31:0]       data_wdata_out;
  logic              data_gnt_in;
  logic              data_rvalid_in;
  logic [31:0]       data_rdata_in;

  modport master (
    output data_req_out,
    output data_addr_out,
    output data_we_out,
    output data_be_out,
    output data_wdata_out,
    input  data_gnt_in,
    input  data_rvalid_in,
    input  data_rdata_in
  );

  modport slave (
    input  data_req_out,
    input  data_addr_out,
    input  data_we_out,
    input  data_be_out,
    input  data_wdata_out,
    output data_gnt_in,
    output data_rvalid_in,
    output data_rdata_in
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on the data bus and returns the
// write-back triple; non-memory results pass through with one cycle of latency.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic        req,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic [2:0]  funct3_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  output logic        busy_out,
  mem_stage_if.master dbus,
  output logic        valid_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out,
  output logic        err_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_p1;
  logic [2:0]        f3_p1;
  logic [4:0]        rd_p1;
  logic              we_p1;
  logic [3:0]        be_p1;
  logic [31:0]       wdata_p1;
  logic              vld_p2;
  logic              err_p2;
  logic [4:0]        rd_p2;
  logic              rd_we_p2;
  logic [31:0]       rd_val_p2;

  logic [ADDR_W-1:0] acc_addr;
  logic              is_mem;
  logic              bad_f3;
  logic              misalign;
  logic              acc_err;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = 4'b0011 << {off[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3[1:0])
      2'b00:   store_data = {4{rs2[7:0]}};
      2'b01:   store_data = {2{rs2[15:0]}};
      default: store_data = rs2;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0]        lane;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    lane   = rdata >> {off, 3'b000};
    lane_b = lane[7:0];
    lane_h = lane[15:0];
    case (f3)
      3'b000:  load_fmt = 32'(lane_b);
      3'b001:  load_fmt = 32'(lane_h);
      3'b100:  load_fmt = {24'b0, lane[7:0]};
      3'b101:  load_fmt = {16'b0, lane[15:0]};
      default: load_fmt = lane;
    endcase
  endfunction

  // A set mem_read_in wins, so read+write is decoded as a load.
  always_comb begin
    acc_addr = result_in[ADDR_W-1:0];
    is_mem   = mem_read_in || mem_write_in;
    bad_f3   = mem_read_in ? (funct3_in == 3'b011 || funct3_in[2:1] == 2'b11)
                           : (funct3_in[2] || funct3_in == 3'b011);
    misalign = (funct3_in[1:0] == 2'b01 && acc_addr[0]) ||
               (funct3_in[1:0] == 2'b10 && acc_addr[1:0] != 2'b00);
    acc_err  = is_mem && (bad_f3 || misalign);
  end

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_p1   <= '0;
      f3_p1     <= '0;
      rd_p1     <= '0;
      we_p1     <= 1'b0;
      be_p1     <= '0;
      wdata_p1  <= '0;
      vld_p2    <= 1'b0;
      err_p2    <= 1'b0;
      rd_p2     <= '0;
      rd_we_p2  <= 1'b0;
      rd_val_p2 <= '0;
    end else begin
      vld_p2 <= 1'b0;
      err_p2 <= 1'b0;
      case (state)
        // p0 -> p1: accept from execute; pass-through and faults finish here
        IDLE: begin
          if (valid_in) begin
            if (!is_mem) begin
              vld_p2    <= 1'b1;
              rd_p2     <= rd_in;
              rd_we_p2  <= rd_write_in && (rd_in != 5'd0);
              rd_val_p2 <= result_in;
            end else if (acc_err) begin
              vld_p2    <= 1'b1;
              err_p2    <= 1'b1;
              rd_p2     <= rd_in;
              rd_we_p2  <= 1'b0;
              rd_val_p2 <= '0;
            end else begin
              state    <= REQ;
              addr_p1  <= acc_addr;
              f3_p1    <= funct3_in;
              rd_p1    <= rd_in;
              we_p1    <= !mem_read_in;
              be_p1    <= mem_read_in ? 4'b0000 : byte_en(funct3_in, acc_addr[1:0]);
              wdata_p1 <= mem_read_in ? 32'd0 : store_data(funct3_in, rs2_value_in);
            end
          end
        end
        REQ: begin
          if (dbus.data_gnt_in) state <= WAIT;
        end
        // p1 -> p2: bus response becomes the write-back triple
        WAIT: begin
          if (dbus.data_rvalid_in) begin
            state     <= IDLE;
            vld_p2    <= 1'b1;
            rd_p2     <= rd_p1;
            rd_we_p2  <= !we_p1 && (rd_p1 != 5'd0);
            rd_val_p2 <= we_p1 ? 32'd0 : load_fmt(f3_p1, addr_p1[1:0], dbus.data_rdata_in);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_out            = (state != IDLE);
  assign dbus.data_req_out   = (state == REQ);
  assign dbus.data_addr_out  = {addr_p1[ADDR_W-1:2], 2'b00};
  assign dbus.data_we_out    = we_p1;
  assign dbus.data_be_out    = be_p1;
  assign dbus.data_wdata_out = wdata_p1;

  assign valid_out    = vld_p2;
  assign err_out      = err_p2;
  assign rd_out       = rd_p2;
  assign rd_write_out = rd_we_p2;
  assign rd_value_out = rd_val_p2;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table for single-cycle results,
// scoreboarded memory transactions and reset-abort sequences.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in;
  logic [31:0] result_in;
  logic [31:0] rs2_value_in;
  logic [2:0]  funct3_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic        busy_out;
  logic        valid_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] rd_value_out;
  logic        err_out;

  always #5 clk = ~clk;

  mem_stage_if #(.ADDR_W(32)) dbus ();

  mem_stage #(.ADDR_W(32)) dut (
    .req          (clk),
    .reset        (rst_n),
    .valid_in     (valid_in),
    .result_in    (result_in),
    .rs2_value_in (rs2_value_in),
    .funct3_in    (funct3_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .rd_in        (rd_in),
    .rd_write_in  (rd_write_in),
    .busy_out     (busy_out),
    .dbus         (dbus),
    .valid_out    (valid_out),
    .rd_out       (rd_out),
    .rd_write_out (rd_write_out),
    .rd_value_out (rd_value_out),
    .err_out      (err_out)
  );

  typedef struct {
    logic        err;
    logic        rdw;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        chk_val;
  } exp_t;

  typedef struct {
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rdw;
    logic        err;
    logic        exp_rdw;
  } vec_t;

  exp_t sb[$];
  vec_t vt[10];
  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;
  int   vcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    if (rst_n && valid_out) begin
      vcnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_out actual=pulse(rd=%0d val=%0h) required=none",
                 rd_out, rd_value_out);
      end else begin
        e = sb.pop_front();
        chk("wb_err", 64'(err_out), 64'(e.err));
        chk("wb_rd_write", 64'(rd_write_out), 64'(e.rdw));
        if (!e.err) chk("wb_rd", 64'(rd_out), 64'(e.rd));
        if (e.chk_val) chk("wb_value", 64'(rd_value_out), 64'(e.val));
      end
    end
    if (rst_n && dbus.data_req_out) req_cnt++;
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
  endtask

  task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] res, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic rdw);
    valid_in     = 1'b1;
    mem_read_in  = mr;
    mem_write_in = mw;
    funct3_in    = f3;
    result_in    = res;
    rs2_value_in = rs2;
    rd_in        = rd;
    rd_write_in  = rdw;
  endtask

  task automatic mem_op(input string nm, input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                        input int nreq, input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_val,
                        input logic exp_rdw, input logic exp_we, input logic hold,
                        input logic spur);
    exp_t        e;
    int          r0;
    int          v0;
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    e = '{1'b0, exp_rdw, rd, exp_val, 1'b1};
    sb.push_back(e);
    r0 = req_cnt;
    v0 = vcnt;
    drive(mr, mw, f3, addr, rs2, rd, 1'b1);
    dbus.data_rdata_in = 32'hDEAD_DEAD;
    cycle();
    if (!hold) valid_in = 1'b0;
    for (int i = 0; i < nreq; i++) begin
      chk({nm, "_req"}, 64'(dbus.data_req_out), 64'(1));
      chk({nm, "_addr"}, 64'(dbus.data_addr_out), 64'(waddr));
      chk({nm, "_we"}, 64'(dbus.data_we_out), 64'(exp_we));
      chk({nm, "_be"}, 64'(dbus.data_be_out), 64'(exp_be));
      if (exp_we) chk({nm, "_wdata"}, 64'(dbus.data_wdata_out), 64'(exp_wdata));
      chk({nm, "_no_early_valid"}, 64'(valid_out), 64'(0));
      dbus.data_gnt_in    = (i == nreq - 1);
      dbus.data_rvalid_in = spur && (i == 0);
      cycle();
    end
    dbus.data_gnt_in    = 1'b0;
    dbus.data_rvalid_in = 1'b0;
    chk({nm, "_wait_req"}, 64'(dbus.data_req_out), 64'(0));
    chk({nm, "_wait_busy"}, 64'(busy_out), 64'(1));
    chk({nm, "_wait_valid"}, 64'(valid_out), 64'(0));
    dbus.data_rvalid_in = 1'b1;
    dbus.data_rdata_in  = rdata;
    cycle();
    dbus.data_rvalid_in = 1'b0;
    dbus.data_rdata_in  = 32'hDEAD_DEAD;
    valid_in = 1'b0;
    chk({nm, "_done_valid"}, 64'(valid_out), 64'(1));
    chk({nm, "_done_busy"}, 64'(busy_out), 64'(0));
    chk({nm, "_req_cycles"}, 64'(req_cnt - r0), 64'(nreq));
    cycle();
    chk({nm, "_pulse"}, 64'(valid_out), 64'(0));
    chk({nm, "_idle"}, 64'(busy_out), 64'(0));
    chk({nm, "_hold_value"}, 64'(rd_value_out), 64'(exp_val));
    chk({nm, "_one_pulse"}, 64'(vcnt - v0), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   r0;
    int   v0;
    valid_in = 1'b0; result_in = '0; rs2_value_in = '0; funct3_in = '0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; rd_in = '0; rd_write_in = 1'b0;
    dbus.data_gnt_in = 1'b0; dbus.data_rvalid_in = 1'b0; dbus.data_rdata_in = '0;

    #1;
    chk("reset_ctrl", 64'({busy_out, dbus.data_req_out, valid_out, err_out, rd_write_out,
                           rd_out, rd_value_out, dbus.data_we_out, dbus.data_be_out}), 64'(0));
    chk("reset_bus", 64'({dbus.data_addr_out, dbus.data_wdata_out}), 64'(0));
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    vt[0] = '{1'b0, 1'b0, 3'b000, 32'h0000_002A, 5'd3,  1'b1, 1'b0, 1'b1};
    vt[1] = '{1'b0, 1'b0, 3'b010, 32'h0000_0055, 5'd0,  1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 3'b111, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 3'b010, 32'h0000_0006, 5'd4,  1'b1, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 5'd4,  1'b1, 1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 5'd4,  1'b1, 1'b1, 1'b0};
    vt[6] = '{1'b1, 1'b0, 3'b001, 32'h0000_0001, 5'd6,  1'b1, 1'b1, 1'b0};
    vt[7] = '{1'b0, 1'b1, 3'b010, 32'h0000_0002, 5'd6,  1'b1, 1'b1, 1'b0};
    vt[8] = '{1'b1, 1'b1, 3'b110, 32'h0000_0008, 5'd6,  1'b1, 1'b1, 1'b0};
    vt[9] = '{1'b1, 1'b0, 3'b101, 32'h0000_0005, 5'd7,  1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      r0 = req_cnt;
      e = '{vt[i].err, vt[i].exp_rdw, vt[i].rd, vt[i].res, !vt[i].err};
      sb.push_back(e);
      drive(vt[i].mr, vt[i].mw, vt[i].f3, vt[i].res, 32'h5A5A_5A5A, vt[i].rd, vt[i].rdw);
      cycle();
      valid_in = 1'b0;
      chk("vec_valid", 64'(valid_out), 64'(1));
      chk("vec_err", 64'(err_out), 64'(vt[i].err));
      chk("vec_busy", 64'(busy_out), 64'(0));
      cycle();
      chk("vec_valid_pulse", 64'(valid_out), 64'(0));
      chk("vec_err_pulse", 64'(err_out), 64'(0));
      chk("vec_no_req", 64'(req_cnt - r0), 64'(0));
    end

    mem_op("lb",   1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5, 2, 32'h80FF_0000,
           4'b0000, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_op("sh",   1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd7, 1, 32'hFFFF_FFFF,
           4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    mem_op("lhu",  1'b1, 1'b0, 3'b101, 32'h0000_0006, 32'h0, 5'd8, 1, 32'h8001_0000,
           4'b0000, 32'h0, 32'h0000_8001, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_op("lh",   1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 5'd9, 1, 32'h8001_0000,
           4'b0000, 32'h0, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_op("lbu",  1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0, 5'd10, 3, 32'h0000_F100,
           4'b0000, 32'h0, 32'h0000_00F1, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_op("sb",   1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00EF, 5'd11, 1, 32'h0,
           4'b1000, 32'hEFEF_EFEF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    mem_op("sw",   1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 5'd1, 2, 32'h0,
           4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    mem_op("lw_x0", 1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0, 5'd0, 1, 32'h1234_5678,
           4'b0000, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_op("rw_load", 1'b1, 1'b1, 3'b010, 32'h0000_0024, 32'h1111_1111, 5'd13, 1, 32'h0BAD_F00D,
           4'b0000, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_op("hold", 1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd12, 2, 32'hA5A5_5A5A,
           4'b0000, 32'h0, 32'hA5A5_5A5A, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset while a request is outstanding.
    e = '{1'b0, 1'b1, 5'd14, 32'h0, 1'b0};
    sb.push_back(e);
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd14, 1'b1);
    cycle();
    valid_in = 1'b0;
    chk("rst_req_before", 64'(dbus.data_req_out), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_drop", 64'(dbus.data_req_out), 64'(0));
    chk("rst_req_busy", 64'(busy_out), 64'(0));
    sb.delete();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Reset while waiting for the response; the late rvalid must be ignored.
    v0 = vcnt;
    e = '{1'b0, 1'b1, 5'd15, 32'h0, 1'b0};
    sb.push_back(e);
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 5'd15, 1'b1);
    cycle();
    valid_in = 1'b0;
    dbus.data_gnt_in = 1'b1;
    cycle();
    dbus.data_gnt_in = 1'b0;
    chk("rst_wait_busy_before", 64'(busy_out), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_busy", 64'(busy_out), 64'(0));
    chk("rst_wait_req", 64'(dbus.data_req_out), 64'(0));
    chk("rst_wait_valid", 64'(valid_out), 64'(0));
    chk("rst_wait_outs", 64'({rd_out, rd_write_out, rd_value_out}), 64'(0));
    sb.delete();
    cycle();
    rst_n = 1'b1;
    dbus.data_rvalid_in = 1'b1;
    dbus.data_gnt_in    = 1'b1;
    dbus.data_rdata_in  = 32'h7777_7777;
    cycle();
    dbus.data_rvalid_in = 1'b0;
    dbus.data_gnt_in    = 1'b0;
    cycle();
    chk("rst_late_rvalid_valid", 64'(valid_out), 64'(0));
    chk("rst_late_rvalid_busy", 64'(busy_out), 64'(0));
    chk("rst_late_rvalid_count", 64'(vcnt - v0), 64'(0));

    // Recovery: a pass-through op after the aborted transaction.
    e = '{1'b0, 1'b1, 5'd2, 32'h0000_0077, 1'b1};
    sb.push_back(e);
    drive(1'b0, 1'b0, 3'b000, 32'h0000_0077, 32'h0, 5'd2, 1'b1);
    cycle();
    valid_in = 1'b0;
    chk("recover_valid", 64'(valid_out), 64'(1));
    cycle();
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
